// File: rtl/mesh_boundary_controller_pkg.sv
// Shared constants for the mesh boundary controller: FSM encodings, defaults, width helper.
package mesh_boundary_controller_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DUMP  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int unsigned DEF_PKT_WIDTH    = 4;
  localparam int unsigned DEF_NUM_OUT      = 4;
  localparam int unsigned DEF_STEP_NUMBER  = 32;
  localparam int unsigned DEF_STEP_CYCLE   = 64;
  localparam int unsigned DEF_GUARD_CYCLES = 4;
  localparam int unsigned DEF_DRAIN_CYCLES = 16;
  localparam int unsigned DEF_FIFO_DEPTH   = 8;
  localparam int unsigned DEF_CNT_WIDTH    = 8;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/mesh_boundary_controller_if.sv
// Host/router-facing signal bundle of the mesh boundary controller.
interface mesh_boundary_controller_if
  import mesh_boundary_controller_pkg::*;
#(
  parameter int unsigned PKT_WIDTH   = DEF_PKT_WIDTH,
  parameter int unsigned NUM_OUT     = DEF_NUM_OUT,
  parameter int unsigned STEP_NUMBER = DEF_STEP_NUMBER,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) ();

  localparam int unsigned ID_W   = clog2_min1(NUM_OUT);
  localparam int unsigned STEP_W = clog2_min1(STEP_NUMBER);

  logic                 enable;
  logic                 start;
  logic [STEP_W-1:0]    step_idx;
  logic                 stim_valid;
  logic [PKT_WIDTH-1:0] stim_packet;
  logic                 stim_ready;
  logic [PKT_WIDTH-1:0] inj_packet;
  logic                 inj_write_req;
  logic                 inj_full;
  logic [PKT_WIDTH-1:0] rx_packet;
  logic                 rx_write_en;
  logic                 rx_full;
  logic                 result_valid;
  logic [ID_W-1:0]      result_id;
  logic [CNT_WIDTH-1:0] result_count;
  logic [CNT_WIDTH-1:0] drop_count;
  logic                 done;

  // Host / router side.
  modport master (
    output enable, stim_valid, stim_packet, inj_full, rx_packet, rx_write_en,
    input  start, step_idx, stim_ready, inj_packet, inj_write_req, rx_full,
           result_valid, result_id, result_count, drop_count, done
  );

  // Controller side.
  modport slave (
    input  enable, stim_valid, stim_packet, inj_full, rx_packet, rx_write_en,
    output start, step_idx, stim_ready, inj_packet, inj_write_req, rx_full,
           result_valid, result_id, result_count, drop_count, done
  );

endinterface

// File: rtl/mesh_boundary_controller_spike_fifo.sv
// Synchronous injection FIFO with registered full/empty flags and a flush.
module spike_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic [AW:0]      count_n;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;
  assign dout    = mem[rd_ptr];
  assign full    = full_q;
  assign empty   = empty_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_n = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  // Storage array; needs no reset since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_n;
      full_q  <= (count_n == (AW+1)'(DEPTH));
      empty_q <= (count_n == '0);
    end
  end

endmodule

// File: rtl/mesh_boundary_controller.sv
// Run sequencer, stimulus injector and per-neuron spike counter bank for one mesh boundary.
module mesh_boundary_controller
  import mesh_boundary_controller_pkg::*;
#(
  parameter int unsigned PKT_WIDTH    = DEF_PKT_WIDTH,
  parameter int unsigned NUM_OUT      = DEF_NUM_OUT,
  parameter int unsigned STEP_NUMBER  = DEF_STEP_NUMBER,
  parameter int unsigned STEP_CYCLE   = DEF_STEP_CYCLE,
  parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                        rt_clk,
  input  logic                        rt_reset,
  mesh_boundary_controller_if.slave   bus
);

  localparam int unsigned ID_W      = clog2_min1(NUM_OUT);
  localparam int unsigned STEP_W    = clog2_min1(STEP_NUMBER);
  localparam int unsigned SPAN_A    = (STEP_CYCLE > DRAIN_CYCLES) ? STEP_CYCLE : DRAIN_CYCLES;
  localparam int unsigned SPAN      = (SPAN_A > NUM_OUT) ? SPAN_A : NUM_OUT;
  localparam int unsigned CYC_W     = clog2_min1(SPAN + 1);
  localparam int unsigned INJ_LIMIT = STEP_CYCLE - GUARD_CYCLES;

  logic [2:0]           state_q, state_n;
  logic [CYC_W-1:0]     cyc_q, cyc_n;
  logic [STEP_W-1:0]    step_q, step_n;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_OUT];
  logic [CNT_WIDTH-1:0] cnt_n [NUM_OUT];
  logic [CNT_WIDTH-1:0] drop_q, drop_n;
  logic                 enable_q;
  logic [ID_W-1:0]      rx_idx;

  logic                 start_q, start_n;
  logic                 rx_full_q, rx_full_n;
  logic                 inj_wr_q, inj_wr_n;
  logic [PKT_WIDTH-1:0] inj_pkt_q, inj_pkt_n;
  logic                 res_valid_q, res_valid_n;
  logic [ID_W-1:0]      res_id_q, res_id_n;
  logic [CNT_WIDTH-1:0] res_cnt_q, res_cnt_n;
  logic                 done_q, done_n;

  logic                 fifo_pop;
  logic                 fifo_flush;
  logic [PKT_WIDTH-1:0] fifo_head;
  logic                 fifo_empty;
  logic                 fifo_full;

  // Injection buffer between host stimulus and the router local port.
  spike_fifo #(
    .WIDTH (PKT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (rt_clk),
    .rst   (rt_reset),
    .flush (fifo_flush),
    .push  (bus.stim_valid),
    .din   (bus.stim_packet),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.start         = start_q;
  assign bus.step_idx      = step_q;
  assign bus.stim_ready    = !fifo_full;
  assign bus.inj_packet    = inj_pkt_q;
  assign bus.inj_write_req = inj_wr_q;
  assign bus.rx_full       = rx_full_q;
  assign bus.result_valid  = res_valid_q;
  assign bus.result_id     = res_id_q;
  assign bus.result_count  = res_cnt_q;
  assign bus.drop_count    = drop_q;
  assign bus.done          = done_q;

  // Next-state, counter-bank and registered-output logic.
  always_comb begin
    state_n    = state_q;
    cyc_n      = cyc_q;
    step_n     = step_q;
    cnt_n      = cnt_q;
    drop_n     = drop_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    rx_idx     = ID_W'(bus.rx_packet);

    // A packet value not below NUM_OUT addresses no counter and is tallied as a drop.
    if (bus.rx_write_en && !rx_full_q) begin
      if (32'(bus.rx_packet) < NUM_OUT) begin
        if (!(&cnt_n[rx_idx])) cnt_n[rx_idx] = cnt_n[rx_idx] + CNT_WIDTH'(1);
      end else if (!(&drop_n)) begin
        drop_n = drop_n + CNT_WIDTH'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.enable && !enable_q) begin
          state_n = ST_RUN;
          cyc_n   = '0;
          step_n  = '0;
          drop_n  = '0;
          for (int i = 0; i < NUM_OUT; i++) cnt_n[i] = '0;
        end
      end
      ST_RUN: begin
        fifo_pop = !fifo_empty && !bus.inj_full && (cyc_q < CYC_W'(INJ_LIMIT));
        if (cyc_q == CYC_W'(STEP_CYCLE - 1)) begin
          cyc_n = '0;
          if (step_q == STEP_W'(STEP_NUMBER - 1)) state_n = ST_DRAIN;
          else                                    step_n  = step_q + STEP_W'(1);
        end else begin
          cyc_n = cyc_q + CYC_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cyc_q == CYC_W'(DRAIN_CYCLES - 1)) begin
          state_n = ST_DUMP;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_q + CYC_W'(1);
        end
      end
      ST_DUMP: begin
        if (cyc_q == CYC_W'(NUM_OUT - 1)) begin
          state_n = ST_DONE;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_q + CYC_W'(1);
        end
      end
      ST_DONE:  state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase

    // Dropping enable outside IDLE aborts; queued stimulus is discarded, counts are kept.
    if ((state_q != ST_IDLE) && !bus.enable) begin
      state_n    = ST_IDLE;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b1;
    end

    start_n     = (state_n == ST_RUN) && (cyc_n == '0);
    rx_full_n   = !((state_n == ST_RUN) || (state_n == ST_DRAIN));
    inj_wr_n    = fifo_pop;
    inj_pkt_n   = fifo_pop ? fifo_head : inj_pkt_q;
    res_valid_n = (state_n == ST_DUMP);
    res_id_n    = res_valid_n ? ID_W'(cyc_n) : '0;
    res_cnt_n   = res_valid_n ? cnt_n[ID_W'(cyc_n)] : '0;
    done_n      = (state_n == ST_DONE);
  end

  // State, counters and output registers.
  always_ff @(posedge rt_clk or posedge rt_reset) begin
    if (rt_reset) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      step_q      <= '0;
      drop_q      <= '0;
      enable_q    <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= '0;
      start_q     <= 1'b0;
      rx_full_q   <= 1'b1;
      inj_wr_q    <= 1'b0;
      inj_pkt_q   <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cyc_q       <= cyc_n;
      step_q      <= step_n;
      drop_q      <= drop_n;
      enable_q    <= bus.enable;
      for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= cnt_n[i];
      start_q     <= start_n;
      rx_full_q   <= rx_full_n;
      inj_wr_q    <= inj_wr_n;
      inj_pkt_q   <= inj_pkt_n;
      res_valid_q <= res_valid_n;
      res_id_q    <= res_id_n;
      res_cnt_q   <= res_cnt_n;
      done_q      <= done_n;
    end
  end

endmodule

// File: tb/tb_mesh_boundary_controller.sv
// Directed self-checking bench for mesh_boundary_controller (2 steps x 8 cycles, 2-bit counters).
module tb_mesh_boundary_controller;

  localparam int unsigned PKT_WIDTH    = 4;
  localparam int unsigned NUM_OUT      = 4;
  localparam int unsigned STEP_NUMBER  = 2;
  localparam int unsigned STEP_CYCLE   = 8;
  localparam int unsigned GUARD_CYCLES = 2;
  localparam int unsigned DRAIN_CYCLES = 4;
  localparam int unsigned FIFO_DEPTH   = 8;
  localparam int unsigned CNT_WIDTH    = 2;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n;
  int   n_wr;

  mesh_boundary_controller_if #(
    .PKT_WIDTH   (PKT_WIDTH),
    .NUM_OUT     (NUM_OUT),
    .STEP_NUMBER (STEP_NUMBER),
    .CNT_WIDTH   (CNT_WIDTH)
  ) bus ();

  mesh_boundary_controller #(
    .PKT_WIDTH    (PKT_WIDTH),
    .NUM_OUT      (NUM_OUT),
    .STEP_NUMBER  (STEP_NUMBER),
    .STEP_CYCLE   (STEP_CYCLE),
    .GUARD_CYCLES (GUARD_CYCLES),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .CNT_WIDTH    (CNT_WIDTH)
  ) dut (
    .rt_clk   (clk),
    .rt_reset (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] p);
    bus.stim_valid  = 1'b1;
    bus.stim_packet = p;
    tick();
    bus.stim_valid  = 1'b0;
  endtask

  task automatic rx(input logic [3:0] p);
    bus.rx_write_en = 1'b1;
    bus.rx_packet   = p;
    tick();
    bus.rx_write_en = 1'b0;
  endtask

  task automatic wait_start(input int limit, output int cnt);
    cnt = 0;
    while (cnt < limit) begin
      tick();
      cnt++;
      if (bus.start) break;
    end
    if (!bus.start) chk("start_timeout", 32'(bus.start), 1);
  endtask

  task automatic wait_valid(input int limit, output int cnt);
    cnt = 0;
    while (!bus.result_valid && cnt < limit) begin
      tick();
      cnt++;
    end
    if (!bus.result_valid) chk("valid_timeout", 32'(bus.result_valid), 1);
  endtask

  task automatic check_dump(input string tag, input int c0, input int c1, input int c2, input int c3);
    int e [4];
    e = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 32'(bus.result_valid), 1);
      chk($sformatf("%s_id%0d", tag, i), 32'(bus.result_id), 32'(i));
      chk($sformatf("%s_cnt%0d", tag, i), 32'(bus.result_count), 32'(e[i]));
      tick();
    end
    chk($sformatf("%s_done", tag), 32'(bus.done), 1);
    chk($sformatf("%s_valid_end", tag), 32'(bus.result_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.enable      = 1'b0;
    bus.stim_valid  = 1'b0;
    bus.stim_packet = '0;
    bus.inj_full    = 1'b0;
    bus.rx_packet   = '0;
    bus.rx_write_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Reset values
    chk("rst_start",      32'(bus.start), 0);
    chk("rst_step",       32'(bus.step_idx), 0);
    chk("rst_stim_ready", 32'(bus.stim_ready), 1);
    chk("rst_inj_wr",     32'(bus.inj_write_req), 0);
    chk("rst_inj_pkt",    32'(bus.inj_packet), 0);
    chk("rst_rx_full",    32'(bus.rx_full), 1);
    chk("rst_valid",      32'(bus.result_valid), 0);
    chk("rst_id",         32'(bus.result_id), 0);
    chk("rst_count",      32'(bus.result_count), 0);
    chk("rst_drop",       32'(bus.drop_count), 0);
    chk("rst_done",       32'(bus.done), 0);

    // 1: empty run, start spacing, drain length, zero dump
    bus.enable = 1'b1;
    tick();
    chk("t1_start0", 32'(bus.start), 1);
    chk("t1_step0",  32'(bus.step_idx), 0);
    chk("t1_rx_open", 32'(bus.rx_full), 0);
    wait_start(20, n);
    chk("t1_gap",   32'(n), 8);
    chk("t1_step1", 32'(bus.step_idx), 1);
    wait_valid(40, n);
    chk("t1_to_dump", 32'(n), 12);
    check_dump("t1", 0, 0, 0, 0);
    tick();
    chk("t1_done_hold", 32'(bus.done), 1);
    bus.enable = 1'b0;
    tick();
    chk("t1_done_clr", 32'(bus.done), 0);
    chk("t1_rx_closed", 32'(bus.rx_full), 1);

    // 2: three queued packets injected back to back in order
    push(4'd5);
    push(4'd9);
    push(4'd12);
    bus.enable = 1'b1;
    tick();
    chk("t2_start", 32'(bus.start), 1);
    tick();
    chk("t2_wr0",  32'(bus.inj_write_req), 1);
    chk("t2_pkt0", 32'(bus.inj_packet), 5);
    tick();
    chk("t2_wr1",  32'(bus.inj_write_req), 1);
    chk("t2_pkt1", 32'(bus.inj_packet), 9);
    tick();
    chk("t2_wr2",  32'(bus.inj_write_req), 1);
    chk("t2_pkt2", 32'(bus.inj_packet), 12);
    tick();
    chk("t2_wr_idle", 32'(bus.inj_write_req), 0);
    bus.enable = 1'b0;
    tick();

    // 3: full FIFO, ignored ninth push, guard window holds injection
    bus.inj_full = 1'b1;
    for (int i = 1; i <= 8; i++) push(4'(i));
    chk("t3_ready_full", 32'(bus.stim_ready), 0);
    push(4'd15);
    chk("t3_ready_still", 32'(bus.stim_ready), 0);
    bus.enable = 1'b1;
    tick();
    chk("t3_start", 32'(bus.start), 1);
    repeat (6) tick();
    chk("t3_wr_cyc6", 32'(bus.inj_write_req), 0);
    bus.inj_full = 1'b0;
    tick();
    chk("t3_wr_cyc7", 32'(bus.inj_write_req), 0);
    tick();
    chk("t3_start1", 32'(bus.start), 1);
    chk("t3_step1",  32'(bus.step_idx), 1);
    chk("t3_wr_guard", 32'(bus.inj_write_req), 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("t3_wr%0d", i),  32'(bus.inj_write_req), 1);
      chk($sformatf("t3_pkt%0d", i), 32'(bus.inj_packet), 32'(i));
    end
    tick();
    chk("t3_wr_guard2", 32'(bus.inj_write_req), 0);
    chk("t3_ready_back", 32'(bus.stim_ready), 1);
    bus.enable = 1'b0;
    tick();

    // 4: spike counting, saturation, drops, rx ignored once closed
    bus.enable = 1'b1;
    tick();
    repeat (5) rx(4'd2);
    chk("t4_drop0", 32'(bus.drop_count), 0);
    rx(4'd7);
    chk("t4_drop1", 32'(bus.drop_count), 1);
    rx(4'd1);
    rx(4'd1);
    wait_valid(40, n);
    check_dump("t4", 0, 2, 3, 0);
    chk("t4_rx_closed", 32'(bus.rx_full), 1);
    rx(4'd9);
    tick();
    chk("t4_drop_ignored", 32'(bus.drop_count), 1);
    bus.enable = 1'b0;
    tick();

    // 5: abort mid-run flushes the FIFO and keeps counts; re-enable clears them
    bus.inj_full = 1'b1;
    push(4'd3);
    push(4'd4);
    bus.enable = 1'b1;
    tick();
    chk("t5_drop_cleared", 32'(bus.drop_count), 0);
    rx(4'd0);
    rx(4'd7);
    chk("t5_drop_run", 32'(bus.drop_count), 1);
    wait_start(20, n);
    chk("t5_step1", 32'(bus.step_idx), 1);
    tick();
    tick();
    bus.enable = 1'b0;
    tick();
    chk("t5_abort_rx_full", 32'(bus.rx_full), 1);
    chk("t5_abort_start",   32'(bus.start), 0);
    chk("t5_abort_wr",      32'(bus.inj_write_req), 0);
    chk("t5_abort_ready",   32'(bus.stim_ready), 1);
    chk("t5_abort_drop",    32'(bus.drop_count), 1);
    bus.inj_full = 1'b0;
    bus.enable   = 1'b1;
    tick();
    chk("t5_re_start", 32'(bus.start), 1);
    chk("t5_re_step",  32'(bus.step_idx), 0);
    chk("t5_re_drop",  32'(bus.drop_count), 0);
    n_wr = 0;
    repeat (8) begin
      tick();
      if (bus.inj_write_req) n_wr++;
    end
    chk("t5_flushed", 32'(n_wr), 0);
    wait_valid(40, n);
    chk("t5_id0",  32'(bus.result_id), 0);
    chk("t5_cnt0", 32'(bus.result_count), 0);
    tick();
    chk("t5_id1",  32'(bus.result_id), 1);

    // 6: asynchronous reset in the middle of DUMP
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid",   32'(bus.result_valid), 0);
    chk("t6_id",      32'(bus.result_id), 0);
    chk("t6_step",    32'(bus.step_idx), 0);
    chk("t6_rx_full", 32'(bus.rx_full), 1);
    chk("t6_ready",   32'(bus.stim_ready), 1);
    chk("t6_done",    32'(bus.done), 0);
    chk("t6_start",   32'(bus.start), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
